// File: rtl/pz_word_capture_if.sv
// Bus bundle for pz_word_capture: sample inputs, output handshake, status.
// Optional member out_parity exists only when PZ_WORD_PARITY_EN is defined.
`timescale 1ns/1ps
interface pz_word_capture_if #(
  parameter int WORD_W = 16
);
  logic                        pp_0;
  logic                        pz;
  logic                        out_ready;
  logic                        out_valid;
  logic [WORD_W-1:0]           out_word;
  logic                        overflow;
  logic [$clog2(WORD_W)-1:0]   bit_cnt;
`ifdef PZ_WORD_PARITY_EN
  logic                        out_parity;

  modport master (output pp_0, pz, out_ready,
                  input  out_valid, out_word, overflow, bit_cnt, out_parity);
  modport slave  (input  pp_0, pz, out_ready,
                  output out_valid, out_word, overflow, bit_cnt, out_parity);
`else
  modport master (output pp_0, pz, out_ready,
                  input  out_valid, out_word, overflow, bit_cnt);
  modport slave  (input  pp_0, pz, out_ready,
                  output out_valid, out_word, overflow, bit_cnt);
`endif
endinterface

// File: rtl/pz_word_capture.sv
// pz_word_capture: shifts qualified pz samples into WORD_W-bit words
// (first sample lands at MSB) and queues them in a DEPTH-entry buffer
// with a sticky overflow flag for words dropped while full.
// Optional feature macro: PZ_WORD_PARITY_EN adds per-entry parity and out_parity.
`timescale 1ns/1ps
module pz_word_capture #(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic               clock,
  input  logic               reset,
  pz_word_capture_if.slave   bus
);
  localparam int CNT_W = $clog2(WORD_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WORD_W-1:0] r_asm;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_occ;
  logic              r_ovf;

  logic              w_push;
  logic              w_pop;
  logic              w_wr;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  logic [WORD_W-1:0] w_word;

  // Word completes on the enabled sample that fills the last bit position.
  assign w_push  = bus.pp_0 && (r_cnt == CNT_W'(WORD_W - 1));
  assign w_word  = {r_asm[WORD_W-2:0], bus.pz};
  assign w_full  = (r_occ == OCC_W'(DEPTH));
  assign w_empty = (r_occ == '0);
  assign w_pop   = bus.out_ready && !w_empty;
  // When full, a same-edge pop frees the slot the push writes into
  // (wr_ptr == rd_ptr then, and the read uses the pre-edge value).
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  // Serial assembly and sample counter; hold when pp_0 is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_asm <= '0;
      r_cnt <= '0;
    end else if (bus.pp_0) begin
      r_asm <= w_word;
      r_cnt <= w_push ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Buffer pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  // Storage array; contents are only observable through occupancy, so no reset.
  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_word;
  end

  assign bus.out_valid = !w_empty;
  assign bus.out_word  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.overflow  = r_ovf;
  assign bus.bit_cnt   = r_cnt;

`ifdef PZ_WORD_PARITY_EN
  logic r_par [DEPTH];

  // Parity is computed once at push and stored alongside the word.
  always_ff @(posedge clock) begin
    if (w_wr) r_par[r_wr_ptr] <= ^w_word;
  end

  assign bus.out_parity = w_empty ? 1'b0 : r_par[r_rd_ptr];
`endif

endmodule

// File: tb/tb_pz_word_capture.sv
// Self-checking bench for pz_word_capture (WORD_W=16/DEPTH=2 main instance,
// WORD_W=4/DEPTH=4 secondary instance). Parity checks when PZ_WORD_PARITY_EN.
`timescale 1ns/1ps
module tb_pz_word_capture;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total  = 0;
  int   passed = 0;

  always #5 clock = ~clock;

  pz_word_capture_if #(.WORD_W(16)) bus  ();
  pz_word_capture_if #(.WORD_W(4))  bus4 ();

  pz_word_capture #(.WORD_W(16), .DEPTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  pz_word_capture #(.WORD_W(4), .DEPTH(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  // Reference model: queue of completed words, partial word value/length.
  logic [15:0] m_q [$];
  int          m_n;
  int unsigned m_acc;
  logic        m_ovf;

  function automatic void m_clear();
    m_q.delete();
    m_n   = 0;
    m_acc = 0;
    m_ovf = 1'b0;
  endfunction

  function automatic logic [15:0] m_head();
    return (m_q.size() > 0) ? m_q[0] : 16'h0;
  endfunction

  // One clock: drive at negedge, model the edge, return at next negedge.
  task automatic step(input logic pp, input logic z, input logic rdy);
    logic [15:0] dummy;
    bus.pp_0 = pp; bus.pz = z; bus.out_ready = rdy;
    @(posedge clock);
    if (!reset) begin
      if (rdy && m_q.size() > 0) dummy = m_q.pop_front();
      if (pp) begin
        m_acc = (m_acc * 2 + z) % 65536;
        m_n++;
        if (m_n == 16) begin
          m_n = 0;
          if (m_q.size() < 2) m_q.push_back(m_acc[15:0]);
          else m_ovf = 1'b1;
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_clear();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_word !== 16'h0) $display("FAIL reset_word got %h want 0000", bus.out_word); else passed++;
    total++; if (bus.overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.overflow); else passed++;
    total++; if (bus.bit_cnt !== 4'd0) $display("FAIL reset_bitcnt got %0d want 0", bus.bit_cnt); else passed++;
`ifdef PZ_WORD_PARITY_EN
    total++; if (bus.out_parity !== 1'b0) $display("FAIL reset_parity got %b want 0", bus.out_parity); else passed++;
`endif
    m_clear();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_basic_word();
    logic [15:0] pat;
    pat = 16'hB0F5;
    for (int i = 15; i >= 1; i--) step(1'b1, pat[i], 1'b1);
    total++; if (bus.bit_cnt !== 4'd15) $display("FAIL basic_cnt15 got %0d want 15", bus.bit_cnt); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", bus.out_valid); else passed++;
    step(1'b1, pat[0], 1'b1);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", bus.out_valid); else passed++;
    total++; if (bus.out_word !== 16'hB0F5) $display("FAIL basic_word got %h want b0f5", bus.out_word); else passed++;
    total++; if (bus.bit_cnt !== 4'd0) $display("FAIL basic_wrap got %0d want 0", bus.bit_cnt); else passed++;
`ifdef PZ_WORD_PARITY_EN
    total++; if (bus.out_parity !== 1'b1) $display("FAIL basic_parity got %b want 1", bus.out_parity); else passed++;
`endif
    step(1'b0, 1'b0, 1'b1);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_popped got %b want 0", bus.out_valid); else passed++;
  endtask

  task automatic test_enable_gating();
    int errs;
    errs = 0;
    for (int i = 0; i < 32; i++) begin
      step((i % 2) == 0, 1'b1, 1'b0);
      if (bus.bit_cnt !== 4'(m_n)) errs++;
    end
    total++; if (errs != 0) $display("FAIL gate_bitcnt mismatching cycles %0d want 0", errs); else passed++;
    total++; if (bus.out_word !== 16'hFFFF) $display("FAIL gate_word got %h want ffff", bus.out_word); else passed++;
    total++; if (m_head() !== 16'hFFFF) $display("FAIL gate_model got %h want ffff", m_head()); else passed++;
    step(1'b0, 1'b0, 1'b1);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL gate_drain got %b want 0", bus.out_valid); else passed++;
  endtask

  task automatic test_overflow();
    logic [15:0] wa, wb;
    do_reset();
    for (int i = 0; i < 48; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    wa = m_q[0]; wb = m_q[1];
    total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", bus.overflow); else passed++;
    total++; if (bus.out_word !== wa) $display("FAIL ovf_headA got %h want %h", bus.out_word, wa); else passed++;
    step(1'b0, 1'b0, 1'b1);
    total++; if (bus.out_word !== wb) $display("FAIL ovf_headB got %h want %h", bus.out_word, wb); else passed++;
    step(1'b0, 1'b0, 1'b1);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL ovf_empty got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", bus.overflow); else passed++;
  endtask

  task automatic test_full_push_pop();
    logic [15:0] wb, wc;
    do_reset();
    for (int i = 0; i < 47; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    wb = m_q[0]; wc = m_q[1];
    total++; if (bus.overflow !== 1'b0) $display("FAIL fpp_ovf got %b want 0", bus.overflow); else passed++;
    total++; if (bus.out_word !== wb) $display("FAIL fpp_headB got %h want %h", bus.out_word, wb); else passed++;
    step(1'b0, 1'b0, 1'b1);
    total++; if (bus.out_word !== wc) $display("FAIL fpp_headC got %h want %h", bus.out_word, wc); else passed++;
    step(1'b0, 1'b0, 1'b1);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL fpp_empty got %b want 0", bus.out_valid); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 39; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    total++; if (bus.bit_cnt !== 4'd7) $display("FAIL ar_cnt7 got %0d want 7", bus.bit_cnt); else passed++;
    total++; if (bus.out_valid !== 1'b1) $display("FAIL ar_buffered got %b want 1", bus.out_valid); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL ar_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_word !== 16'h0) $display("FAIL ar_word got %h want 0000", bus.out_word); else passed++;
    total++; if (bus.bit_cnt !== 4'd0) $display("FAIL ar_cnt got %0d want 0", bus.bit_cnt); else passed++;
    m_clear();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    total++; if (bus.out_word !== m_head() || bus.out_valid !== 1'b1)
      $display("FAIL ar_newword got %h/%b want %h/1", bus.out_word, bus.out_valid, m_head()); else passed++;
  endtask

  task automatic test_random();
    int e_v, e_w, e_c, e_o;
    e_v = 0; e_w = 0; e_c = 0; e_o = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 3);
      if (bus.out_valid !== (m_q.size() > 0)) e_v++;
      if (bus.out_word !== m_head()) e_w++;
      if (bus.bit_cnt !== 4'(m_n)) e_c++;
      if (bus.overflow !== m_ovf) e_o++;
`ifdef PZ_WORD_PARITY_EN
      if (bus.out_parity !== ^m_head()) e_w++;
`endif
    end
    total++; if (e_v != 0) $display("FAIL rnd_valid bad cycles %0d want 0", e_v); else passed++;
    total++; if (e_w != 0) $display("FAIL rnd_word bad cycles %0d want 0", e_w); else passed++;
    total++; if (e_c != 0) $display("FAIL rnd_bitcnt bad cycles %0d want 0", e_c); else passed++;
    total++; if (e_o != 0) $display("FAIL rnd_ovf bad cycles %0d want 0", e_o); else passed++;
  endtask

  task automatic test_small_wrap();
    logic       bits [20];
    logic [3:0] exp  [4];
    do_reset();
    for (int i = 0; i < 20; i++) bits[i] = 1'($urandom_range(0, 1));
    for (int k = 0; k < 4; k++) begin
      int v;
      v = 0;
      for (int j = 0; j < 4; j++) v = v * 2 + int'(bits[4*k+j]);
      exp[k] = 4'(v);
    end
    for (int i = 0; i < 20; i++) begin
      bus4.pp_0 = 1'b1; bus4.pz = bits[i]; bus4.out_ready = 1'b0;
      @(posedge clock); @(negedge clock);
      if (i == 15) begin
        total++; if (bus4.overflow !== 1'b0) $display("FAIL w4_ovf_early got %b want 0", bus4.overflow); else passed++;
      end
    end
    bus4.pp_0 = 1'b0;
    total++; if (bus4.overflow !== 1'b1) $display("FAIL w4_ovf got %b want 1", bus4.overflow); else passed++;
    for (int k = 0; k < 4; k++) begin
      total++; if (bus4.out_word !== exp[k] || bus4.out_valid !== 1'b1)
        $display("FAIL w4_drain%0d got %h/%b want %h/1", k, bus4.out_word, bus4.out_valid, exp[k]); else passed++;
      bus4.out_ready = 1'b1;
      @(posedge clock); @(negedge clock);
      bus4.out_ready = 1'b0;
    end
    total++; if (bus4.out_valid !== 1'b0) $display("FAIL w4_empty got %b want 0", bus4.out_valid); else passed++;
  endtask

  initial begin
    bus.pp_0 = 1'b0;  bus.pz = 1'b0;  bus.out_ready = 1'b0;
    bus4.pp_0 = 1'b0; bus4.pz = 1'b0; bus4.out_ready = 1'b0;
    test_reset();
    test_basic_word();
    test_enable_gating();
    test_overflow();
    test_full_push_pop();
    test_async_reset();
    test_random();
    test_small_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pz_word_capture.md
PZ_WORD_CAPTURE -- requirements
Module: pz_word_capture

Interface
REQ-001 Parameter WORD_W, default 16, SHALL set the number of pz samples per assembled word (range 2..32).
REQ-002 Parameter DEPTH, default 2, SHALL set the output buffer depth in words (power of two, >= 2).
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pp_0  input  1  sample enable; qualifies pz in the same cycle.
REQ-006 pz  input  1  serial bit from the upstream counter/selector stage.
REQ-007 out_ready  input  1  consumer accepts head word this cycle.
REQ-008 out_valid  output  1  buffer holds at least one word.
REQ-009 out_word  output  WORD_W  head-of-buffer word; first-sampled bit at MSB.
REQ-010 overflow  output  1  sticky flag: a completed word was dropped.
REQ-011 bit_cnt  output  clog2(WORD_W)  samples collected toward the current word.

Function
REQ-012 On a rising clock edge with pp_0=1, the block SHALL shift pz into the LSB of the assembly register and increment bit_cnt.
REQ-013 With pp_0=0, assembly register and bit_cnt SHALL hold.
REQ-014 On the edge where pp_0=1 and bit_cnt=WORD_W-1, the word {assembly[WORD_W-2:0], pz} SHALL be pushed, and bit_cnt SHALL wrap to 0.
REQ-015 A pushed word SHALL appear on out_word/out_valid in the first cycle after the push edge when the buffer was empty (latency 1 clock from final sample).
REQ-016 A pop SHALL occur on an edge with out_valid=1 and out_ready=1; out_word SHALL then show the next entry or out_valid SHALL fall.
REQ-017 out_word SHALL be stable while out_valid=1 and out_ready=0.
REQ-018 Simultaneous push and pop SHALL be accepted in every occupancy state, including full; occupancy unchanged.
REQ-019 Push with buffer full and no pop SHALL drop the new word, leave stored entries intact, and set overflow.
REQ-020 overflow SHALL remain set until reset.
REQ-021 Pop with buffer empty SHALL have no effect.
REQ-022 Buffer read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL range 0..DEPTH.
REQ-023 out_ready SHALL NOT affect sampling; sampling continues while the buffer is full.

Reset
REQ-024 Asserting reset SHALL immediately clear assembly register, bit_cnt, pointers, occupancy, and overflow regardless of clock.
REQ-025 While reset is asserted, out_valid=0, out_word=0, overflow=0, bit_cnt=0.
REQ-026 A partial word in progress at reset SHALL be discarded; the first sample after deassertion starts a new word.
REQ-027 The first edge after deassertion SHALL be treated as normal operation (no dead cycle).

Configuration
REQ-028 Macro PZ_WORD_PARITY_EN defined: a stored parity bit per entry and an output out_parity (1 bit, XOR of all out_word bits, aligned with out_word, 0 under reset) SHALL exist.
REQ-029 Macro PZ_WORD_PARITY_EN undefined: no parity storage and no out_parity port; all other behaviour identical.

Verification
REQ-030 Reset, then pp_0=1 for 16 cycles with pz = 1,0,1,1,0,0,0,0,1,1,1,1,0,1,0,1, out_ready=1 -> out_valid=1 one cycle after 16th sample with out_word=16'hB0F5; popped next edge; out_parity=1 if enabled.
REQ-031 pp_0 toggled 1,0,1,0... across 32 cycles with pz=1 -> bit_cnt advances only on pp_0=1 cycles; one word 16'hFFFF after 16 enabled samples.
REQ-032 out_ready=0, 48 enabled samples (three words A,B,C) -> A and B held in order, C dropped, overflow=1; then out_ready=1 -> A then B, out_valid falls, overflow stays 1.
REQ-033 Buffer full, out_ready=1 on the cycle of a third word's push -> A popped, C accepted, no overflow; subsequent output order B, C.
REQ-034 Reset asserted asynchronously mid-word (bit_cnt=7) and with two words buffered -> outputs clear without a clock edge; next 16 samples form a complete new word.
REQ-035 WORD_W=4, DEPTH=4: 20 enabled samples, out_ready=0 -> four words stored, fifth dropped, overflow=1, pointer wrap verified by draining in order.
